// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if -- request/response bundle for the HI/LO multiply-divide unit.
//
// Signals:
//   start        request a new operation (taken only when the unit is idle)
//   op[1:0]      00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   a, b         rs / rt operands, captured when the request is accepted
//   we_hi, we_lo MTHI / MTLO write strobes
//   wd           MTHI / MTLO write data
//   busy         operation in progress
//   done         one-cycle pulse when HI/LO hold a new result
//   hi, lo       architectural HI / LO registers
//
// Modports: master drives requests (pipeline / testbench), slave is the unit.
interface muldiv_unit_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        we_hi;
    logic        we_lo;
    logic [31:0] wd;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, a, b, we_hi, we_lo, wd,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, we_hi, we_lo, wd,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit -- iterative 32x32 multiply / 32/32 divide unit owning HI and LO.
//
// One radix-2 step per cycle: shift-add multiply, restoring divide. An accepted
// request spends 32 cycles in CALC and one in FIX, so busy is high for 33 cycles
// and done pulses in the cycle after the result lands in HI/LO.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-low reset
//   bus    muldiv_unit_if.slave (start/op/a/b/we_hi/we_lo/wd in, busy/done/hi/lo out)
//
// Configuration:
//   MULDIV_SIGNED_EN  when defined, op 01 (MULT) and op 11 (DIV) are two's-complement;
//                     otherwise they run as MULTU / DIVU and no sign logic is built.
module muldiv_unit (
    input logic          clk,
    input logic          reset,
    muldiv_unit_if.slave bus
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t      state;
    state_t      next_state;
    logic [4:0]  count;
    logic [63:0] acc;
    logic [31:0] opnd;
    logic        is_div;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        done_q;

    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [32:0] mul_sum;
    logic        div_ge;
    logic [31:0] div_rem;
    logic [63:0] prod;
    logic [31:0] quot;
    logic [31:0] rem;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

`ifdef MULDIV_SIGNED_EN
    logic sign_a;
    logic sign_b;
    logic neg_prod;
    logic neg_quot;
    logic neg_rem;
`else
    logic unused_op_sign;
    assign unused_op_sign = bus.op[0];
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.start) next_state = CALC;
            CALC:    if (count == 5'd0) next_state = FIX;
            FIX:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Operand magnitudes; the iterative core only ever sees unsigned values.
    always_comb begin
`ifdef MULDIV_SIGNED_EN
        sign_a = bus.op[0] & bus.a[31];
        sign_b = bus.op[0] & bus.b[31];
        mag_a  = sign_a ? (~bus.a + 32'd1) : bus.a;
        mag_b  = sign_b ? (~bus.b + 32'd1) : bus.b;
`else
        mag_a  = bus.a;
        mag_b  = bus.b;
`endif
    end

    // acc holds {partial product, multiplier} for multiply and
    // {partial remainder, dividend/quotient} for divide. The divide trial uses
    // 33 bits because the shifted remainder can exceed 32 bits before subtracting;
    // when the trial succeeds the true difference always fits in 32 bits.
    always_comb begin
        mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
        div_ge  = acc[63:31] >= {1'b0, opnd};
        div_rem = acc[62:31] - opnd;
    end

    // Sign correction. A zero divisor leaves the quotient alone; the remainder
    // then equals |a| and restoring the dividend's sign yields a itself.
    always_comb begin
`ifdef MULDIV_SIGNED_EN
        prod = neg_prod ? (~acc + 64'd1) : acc;
        quot = neg_quot ? (~acc[31:0] + 32'd1) : acc[31:0];
        rem  = neg_rem  ? (~acc[63:32] + 32'd1) : acc[63:32];
`else
        prod = acc;
        quot = acc[31:0];
        rem  = acc[63:32];
`endif
        res_hi = is_div ? rem  : prod[63:32];
        res_lo = is_div ? quot : prod[31:0];
    end

    // Start takes priority over MTHI/MTLO in IDLE; the strobes are dropped
    // in every other state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count  <= 5'd0;
            acc    <= 64'd0;
            opnd   <= 32'd0;
            is_div <= 1'b0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
            done_q <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            neg_prod <= 1'b0;
            neg_quot <= 1'b0;
            neg_rem  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        acc    <= {32'd0, mag_a};
                        opnd   <= mag_b;
                        is_div <= bus.op[1];
                        count  <= 5'd31;
`ifdef MULDIV_SIGNED_EN
                        neg_prod <= sign_a ^ sign_b;
                        neg_quot <= (sign_a ^ sign_b) & (bus.b != 32'd0);
                        neg_rem  <= sign_a;
`endif
                    end else begin
                        if (bus.we_hi) hi_q <= bus.wd;
                        if (bus.we_lo) lo_q <= bus.wd;
                    end
                end
                CALC: begin
                    if (is_div) begin
                        acc <= div_ge ? {div_rem, acc[30:0], 1'b1} : {acc[62:0], 1'b0};
                    end else begin
                        acc <= {mul_sum, acc[31:1]};
                    end
                    if (count != 5'd0) count <= count - 5'd1;
                end
                FIX: begin
                    hi_q   <= res_hi;
                    lo_q   <= res_lo;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have port: clk  input  1  single rising-edge clock for all state.
REQ-002 SHALL have port: reset  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-003 SHALL have port: start  input  1  request a new operation; accepted only in IDLE.
REQ-004 SHALL have port: op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-005 SHALL have port: a  input  32  multiplicand or dividend (rs), captured on accept.
REQ-006 SHALL have port: b  input  32  multiplier or divisor (rt), captured on accept.
REQ-007 SHALL have port: we_hi, we_lo  input  1 each  MTHI/MTLO write strobes.
REQ-008 SHALL have port: wd  input  32  MTHI/MTLO write data.
REQ-009 SHALL have port: busy  output  1  high while an operation is in progress.
REQ-010 SHALL have port: done  output  1  one-cycle pulse when HI/LO hold a new result.
REQ-011 SHALL have port: hi, lo  output  32 each  HI/LO registers, read by MFHI/MFLO into the register file write-data path.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, FIX; transitions IDLE->CALC on start, CALC->FIX after 32 iterations, FIX->IDLE unconditionally.
REQ-013 SHALL on accept (start=1 in IDLE, edge n) latch op, a, b, form operand magnitudes (signed ops only), and load a 5-bit iteration counter with 31.
REQ-014 SHALL in CALC perform one radix-2 step per cycle: shift-add for multiply (64-bit product), restoring shift-subtract for divide (32-bit quotient, 32-bit remainder).
REQ-015 SHALL in FIX apply sign correction: product negated if operand signs differ; quotient negated if signs differ; remainder takes the sign of the dividend (truncation toward zero).
REQ-016 SHALL write HI/LO at edge n+33: multiply HI=product[63:32], LO=product[31:0]; divide HI=remainder, LO=quotient.
REQ-017 SHALL drive busy=1 for exactly the 33 cycles following edge n and done=1 only in the cycle following edge n+33; busy and done never high together.
REQ-018 SHALL ignore start while busy; no queuing.
REQ-019 SHALL on divisor b==0 produce HI=a and LO=0xFFFFFFFF for DIV and DIVU, with no sign correction.
REQ-020 SHALL produce DIV 0x80000000 / 0xFFFFFFFF as LO=0x80000000, HI=0x00000000 (32-bit wrap, no trap).
REQ-021 SHALL in IDLE load wd into HI on we_hi and into LO on we_lo at the next edge; both may be asserted together.
REQ-022 SHALL drop we_hi/we_lo while busy, and drop them when start is accepted in the same cycle (start wins).
REQ-023 SHALL keep hi/lo stable except on the result write or an accepted MTHI/MTLO write.

Reset
REQ-024 SHALL, when reset=0 at a rising edge, force state IDLE, counter 0, hi=0, lo=0, busy=0, done=0.
REQ-025 SHALL, on reset mid-operation, abort it with no done pulse and no HI/LO result write.
REQ-026 SHALL ignore start, we_hi and we_lo in any cycle where reset=0.

Configuration
REQ-027 SHALL, with MULDIV_SIGNED_EN defined, execute MULT and DIV as two's-complement operations per REQ-015.
REQ-028 SHALL, without MULDIV_SIGNED_EN, omit magnitude/sign-correction logic and execute op 01 as MULTU and op 11 as DIVU; FIX still occupies one cycle, so latency is unchanged.

Verification
REQ-029 SHALL cover: MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001, done exactly 34 cycles after the start edge.
REQ-030 SHALL cover: MULT a=0xFFFFFFFD b=0x00000007 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; without MULDIV_SIGNED_EN -> HI=0x00000006, LO=0xFFFFFFEB.
REQ-031 SHALL cover: DIV a=0xFFFFFFF9 b=0x00000002 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; then DIV a=0x80000000 b=0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-032 SHALL cover: DIVU a=0x00000064 b=0 -> HI=0x00000064, LO=0xFFFFFFFF, normal 33-cycle busy.
REQ-033 SHALL cover: MULTU 3x5 started, start and we_hi pulsed at busy cycle 5 -> ignored, result HI=0, LO=0x0000000F; then in IDLE we_lo with wd=0x12345678 -> LO=0x12345678 next cycle.
REQ-034 SHALL cover: reset=0 at busy cycle 10 -> next cycle busy=0, hi=lo=0, no done pulse; a new start is accepted after reset returns high.
